id_exe_register_fwd: RTL and testbench
======================================

# id_exe_register_fwd

ID/EXE pipeline register for the 5-stage MIPS core, directly upstream of the EXE stage and the EXE/MEM register. It captures decoded control and operands from ID each cycle, inserts bubbles on load-use hazards and on taken branches resolved in MEM (`mem_branch`), and registers the forwarding selects the EXE operand muxes use. Two saturating event counters (stalls, flushes) support performance debug.

## Interface
- `CNT_W`, default 16, width of each saturating event counter
- `clk`  in  1  pipeline clock, all state on rising edge
- `clrn`  in  1  asynchronous reset, active-high; the codebase port name is kept, but the signal is asserted high
- `id_wreg`, `id_m2reg`, `id_wmem`, `id_aluimm`, `id_shift`, `id_is_beq`, `id_is_bne`, `id_wz`  in  1 each  decoded controls
- `id_aluc`  in  4  ALU operation
- `id_a`, `id_b`, `id_imm`  in  32 each  register-file operands, extended immediate
- `id_rs`, `id_rt`, `id_rn`  in  5 each  source registers, destination register
- `id_use_rs`, `id_use_rt`  in  1 each  instruction reads rs / rt
- `mem_branch`  in  1  taken branch resolved in MEM; flush
- `mem_rn`  in  5, `mem_wreg`  in  1  destination and write enable of the instruction in MEM
- `exe_*`  out  same widths as `id_*` (except `id_use_*`)  registered copies
- `exe_fwda`, `exe_fwdb`  out  2 each  forwarding select for the A and B operands
- `stall`  out  1  combinational; holds PC and IF/ID
- `stall_cnt`, `flush_cnt`  out  `CNT_W` each  event counters

## Operation
- Hazard compare, combinational on current inputs and registered `exe_*`:
  - `load_use = exe_m2reg & exe_wreg & (exe_rn != 0) & ((id_use_rs & exe_rn == id_rs) | (id_use_rt & exe_rn == id_rt))`
  - `stall = load_use & ~mem_branch`. A flush overrides a stall.
- Forward select for rs (rt is the same, giving `fwdb`):
  - `FWD_EXE` (01): `exe_wreg & exe_rn != 0 & exe_rn == id_rs & ~exe_m2reg`
  - otherwise `FWD_MEM` (10): `mem_wreg & mem_rn != 0 & mem_rn == id_rs`
  - otherwise `FWD_REG` (00)
  - EXE has priority over MEM. A load sitting in EXE never produces `FWD_EXE`; that case stalls instead.
- Register update on each edge, in priority order:
  - `mem_branch`: load a bubble.
  - `load_use`: load a bubble. ID holds because `stall` is high.
  - otherwise: load all `id_*` fields and both fwd selects.
- Bubble contents: every control bit 0, `exe_aluc` 0, `exe_rn` 0, all 32-bit fields 0, fwd selects `FWD_REG`.
- Counters, saturating at all ones:
  - `stall_cnt` increments each cycle `stall` is high.
  - `flush_cnt` increments each cycle `mem_branch` is high.

## Timing
- Latency is 1 cycle from ID input to `exe_*` output.
- `stall` has no register delay. It is high for exactly one cycle per load-use event, because the bubble removes the load from the compare on the next cycle.
- Reset: every output is 0, which equals a bubble, and both counters are 0. Reset asserted mid-stall clears `stall` on the next evaluation, since `exe_m2reg` becomes 0.
- Flush and load-use in the same cycle: flush wins, `stall` is 0, `flush_cnt` increments and `stall_cnt` does not.
- A counter at its maximum value holds there. There is no wrap.

## Structure
- Shared package `pipe_pkg`:
  - `FWD_REG`, `FWD_EXE`, `FWD_MEM` constants
  - bubble control constant
  - `fwd_sel_t` 2-bit type
- Sub-module `hazard_detect`: combinational; produces `load_use` and the two next fwd selects. It is reused by any future ID-stage logic.
- The top level holds the pipeline flops and the counters.

## Test plan
- Reset held for 3 cycles, then released with `id_wreg=1`, `id_rn=5`, `id_a=0x1234` → outputs are 0 during reset; one edge after release, `exe_rn=5` and `exe_a=0x1234`.
- `lw $8` in EXE (`exe_m2reg=1`, `exe_rn=8`), ID `add` with `rs=8`, `id_use_rs=1` → `stall=1` for one cycle, a bubble is latched, `stall_cnt=1`; on the next edge the `add` latches with `exe_fwda=FWD_MEM` when `mem_rn=8` and `mem_wreg=1`.
- `add $9` in EXE, ID `sub` with `rt=9`; also `mem_rn=9`, `mem_wreg=1` → `exe_fwdb=01`, showing EXE priority over MEM.
- ID uses `rs=0` while `exe_rn=0` and `exe_wreg=1` → `fwda=00`, `stall=0`.
- `mem_branch=1` together with a load-use condition → `stall=0`, a bubble is latched, `flush_cnt=1`, `stall_cnt` unchanged.
- Force `stall_cnt` to 0xFFFF and raise another stall → `stall_cnt` stays 0xFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the 5-stage MIPS core:
// forwarding selects and the ID/EXE bundle with its bubble value.
package pipe_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REG = 2'b00;
  localparam fwd_sel_t FWD_EXE = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic       aluimm;
    logic       shift;
    logic       is_beq;
    logic       is_bne;
    logic       wz;
    logic [3:0] aluc;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rn;
    fwd_sel_t    fwda;
    fwd_sel_t    fwdb;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '{
    ctrl: CTRL_BUBBLE,
    a:    32'd0,
    b:    32'd0,
    imm:  32'd0,
    rs:   5'd0,
    rt:   5'd0,
    rn:   5'd0,
    fwda: FWD_REG,
    fwdb: FWD_REG
  };

  // EXE result wins over MEM; a load in EXE never forwards.
  function automatic fwd_sel_t fwd_pick(
    input logic [4:0] src,
    input logic       exe_wreg,
    input logic       exe_m2reg,
    input logic [4:0] exe_rn,
    input logic       mem_wreg,
    input logic [4:0] mem_rn
  );
    fwd_sel_t sel;
    sel = FWD_REG;
    if (exe_wreg && exe_rn != 5'd0 &&
        exe_rn == src && !exe_m2reg)
      sel = FWD_EXE;
    else if (mem_wreg && mem_rn != 5'd0 &&
             mem_rn == src)
      sel = FWD_MEM;
    return sel;
  endfunction

endpackage

// File: rtl/id_exe_register_fwd_hazard.sv
// Load-use detection and next forwarding selects,
// evaluated on ID operands against the EXE and MEM stages.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       exe_wreg,
  input  logic       exe_m2reg,
  input  logic [4:0] exe_rn,
  input  logic       mem_wreg,
  input  logic [4:0] mem_rn,
  output logic       load_use,
  output logic [1:0] fwda,
  output logic [1:0] fwdb
);

  logic hit_rs;
  logic hit_rt;

  always_comb begin
    hit_rs = id_use_rs && exe_rn == id_rs;
    hit_rt = id_use_rt && exe_rn == id_rt;
    load_use = exe_m2reg && exe_wreg &&
               exe_rn != 5'd0 &&
               (hit_rs || hit_rt);
  end

  always_comb begin
    fwda = fwd_pick(id_rs, exe_wreg, exe_m2reg,
                    exe_rn, mem_wreg, mem_rn);
    fwdb = fwd_pick(id_rt, exe_wreg, exe_m2reg,
                    exe_rn, mem_wreg, mem_rn);
  end

endmodule

// File: rtl/id_exe_register_fwd.sv
// ID/EXE pipeline register with bubble insertion,
// registered forwarding selects and stall/flush counters.
module id_exe_register_fwd
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic             id_wmem,
  input  logic             id_aluimm,
  input  logic             id_shift,
  input  logic             id_is_beq,
  input  logic             id_is_bne,
  input  logic             id_wz,
  input  logic [3:0]       id_aluc,
  input  logic [31:0]      id_a,
  input  logic [31:0]      id_b,
  input  logic [31:0]      id_imm,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rn,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             mem_branch,
  input  logic [4:0]       mem_rn,
  input  logic             mem_wreg,
  output logic             exe_wreg,
  output logic             exe_m2reg,
  output logic             exe_wmem,
  output logic             exe_aluimm,
  output logic             exe_shift,
  output logic             exe_is_beq,
  output logic             exe_is_bne,
  output logic             exe_wz,
  output logic [3:0]       exe_aluc,
  output logic [31:0]      exe_a,
  output logic [31:0]      exe_b,
  output logic [31:0]      exe_imm,
  output logic [4:0]       exe_rs,
  output logic [4:0]       exe_rt,
  output logic [4:0]       exe_rn,
  output logic [1:0]       exe_fwda,
  output logic [1:0]       exe_fwdb,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  id_ex_t           id_ex_q;
  id_ex_t           id_ex_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  logic       load_use;
  logic [1:0] fwda_nx;
  logic [1:0] fwdb_nx;

  hazard_detect u_hazard (
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .exe_wreg  (id_ex_q.ctrl.wreg),
    .exe_m2reg (id_ex_q.ctrl.m2reg),
    .exe_rn    (id_ex_q.rn),
    .mem_wreg  (mem_wreg),
    .mem_rn    (mem_rn),
    .load_use  (load_use),
    .fwda      (fwda_nx),
    .fwdb      (fwdb_nx)
  );

  // A flush squashes the stalled instruction too.
  assign stall = load_use && !mem_branch;

  always_comb begin
    id_ex_d = ID_EX_BUBBLE;
    if (!mem_branch && !load_use) begin
      id_ex_d.ctrl.wreg   = id_wreg;
      id_ex_d.ctrl.m2reg  = id_m2reg;
      id_ex_d.ctrl.wmem   = id_wmem;
      id_ex_d.ctrl.aluimm = id_aluimm;
      id_ex_d.ctrl.shift  = id_shift;
      id_ex_d.ctrl.is_beq = id_is_beq;
      id_ex_d.ctrl.is_bne = id_is_bne;
      id_ex_d.ctrl.wz     = id_wz;
      id_ex_d.ctrl.aluc   = id_aluc;
      id_ex_d.a           = id_a;
      id_ex_d.b           = id_b;
      id_ex_d.imm         = id_imm;
      id_ex_d.rs          = id_rs;
      id_ex_d.rt          = id_rt;
      id_ex_d.rn          = id_rn;
      id_ex_d.fwda        = fwda_nx;
      id_ex_d.fwdb        = fwdb_nx;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && stall_cnt_q != CNT_MAX)
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (mem_branch && flush_cnt_q != CNT_MAX)
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      id_ex_q     <= ID_EX_BUBBLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      id_ex_q     <= id_ex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign exe_wreg   = id_ex_q.ctrl.wreg;
  assign exe_m2reg  = id_ex_q.ctrl.m2reg;
  assign exe_wmem   = id_ex_q.ctrl.wmem;
  assign exe_aluimm = id_ex_q.ctrl.aluimm;
  assign exe_shift  = id_ex_q.ctrl.shift;
  assign exe_is_beq = id_ex_q.ctrl.is_beq;
  assign exe_is_bne = id_ex_q.ctrl.is_bne;
  assign exe_wz     = id_ex_q.ctrl.wz;
  assign exe_aluc   = id_ex_q.ctrl.aluc;
  assign exe_a      = id_ex_q.a;
  assign exe_b      = id_ex_q.b;
  assign exe_imm    = id_ex_q.imm;
  assign exe_rs     = id_ex_q.rs;
  assign exe_rt     = id_ex_q.rt;
  assign exe_rn     = id_ex_q.rn;
  assign exe_fwda   = id_ex_q.fwda;
  assign exe_fwdb   = id_ex_q.fwdb;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_id_exe_register_fwd.sv
// Bench for id_exe_register_fwd: directed scenarios plus
// randomized traffic against a stage-level reference model.
module tb_id_exe_register_fwd;

  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic clk = 1'b0;
  logic clrn = 1'b1;
  logic id_wreg, id_m2reg, id_wmem, id_aluimm;
  logic id_shift, id_is_beq, id_is_bne, id_wz;
  logic [3:0] id_aluc;
  logic [31:0] id_a, id_b, id_imm;
  logic [4:0] id_rs, id_rt, id_rn;
  logic id_use_rs, id_use_rt;
  logic mem_branch;
  logic [4:0] mem_rn;
  logic mem_wreg;
  logic exe_wreg, exe_m2reg, exe_wmem, exe_aluimm;
  logic exe_shift, exe_is_beq, exe_is_bne, exe_wz;
  logic [3:0] exe_aluc;
  logic [31:0] exe_a, exe_b, exe_imm;
  logic [4:0] exe_rs, exe_rt, exe_rn;
  logic [1:0] exe_fwda, exe_fwdb;
  logic stall;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_bad = 0;

  // Model of the instruction currently held in EXE.
  logic [7:0]  m_ctl;
  logic [3:0]  m_aluc;
  logic [31:0] m_a, m_b, m_imm;
  logic [4:0]  m_rs, m_rt, m_rn;
  logic [1:0]  m_fa, m_fb;
  logic [CW-1:0] m_sc, m_fc;

  id_exe_register_fwd #(.CNT_W(CW)) dut (
    .clk(clk), .clrn(clrn),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg),
    .id_wmem(id_wmem), .id_aluimm(id_aluimm),
    .id_shift(id_shift), .id_is_beq(id_is_beq),
    .id_is_bne(id_is_bne), .id_wz(id_wz),
    .id_aluc(id_aluc), .id_a(id_a), .id_b(id_b),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
    .id_rn(id_rn), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .mem_branch(mem_branch),
    .mem_rn(mem_rn), .mem_wreg(mem_wreg),
    .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg),
    .exe_wmem(exe_wmem), .exe_aluimm(exe_aluimm),
    .exe_shift(exe_shift), .exe_is_beq(exe_is_beq),
    .exe_is_bne(exe_is_bne), .exe_wz(exe_wz),
    .exe_aluc(exe_aluc), .exe_a(exe_a), .exe_b(exe_b),
    .exe_imm(exe_imm), .exe_rs(exe_rs), .exe_rt(exe_rt),
    .exe_rn(exe_rn), .exe_fwda(exe_fwda),
    .exe_fwdb(exe_fwdb), .stall(stall),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // m_ctl bit order: wreg m2reg wmem aluimm shift beq bne wz
  function automatic logic m_wreg();
    return m_ctl[7];
  endfunction

  function automatic logic m_load();
    return m_ctl[6];
  endfunction

  function automatic logic exp_lu();
    logic dep;
    dep = (id_use_rs && id_rs == m_rn) ||
          (id_use_rt && id_rt == m_rn);
    return m_load() && m_wreg() && m_rn != 0 && dep;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] r);
    if (m_wreg() && !m_load() && m_rn != 0 && m_rn == r)
      return 2'b01;
    if (mem_wreg && mem_rn != 0 && mem_rn == r)
      return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [7:0] id_ctl();
    return {id_wreg, id_m2reg, id_wmem, id_aluimm,
            id_shift, id_is_beq, id_is_bne, id_wz};
  endfunction

  function automatic logic [7:0] dut_ctl();
    return {exe_wreg, exe_m2reg, exe_wmem, exe_aluimm,
            exe_shift, exe_is_beq, exe_is_bne, exe_wz};
  endfunction

  task automatic m_bubble();
    m_ctl = 0; m_aluc = 0; m_a = 0; m_b = 0; m_imm = 0;
    m_rs = 0; m_rt = 0; m_rn = 0; m_fa = 0; m_fb = 0;
  endtask

  // One clock edge; the model advances on the pre-edge inputs.
  task automatic tick();
    logic lu;
    logic [1:0] fa, fb;
    @(posedge clk);
    if (clrn) begin
      m_bubble();
      m_sc = 0;
      m_fc = 0;
    end else begin
      lu = exp_lu();
      fa = exp_fwd(id_rs);
      fb = exp_fwd(id_rt);
      if (lu && !mem_branch && m_sc != CMAX) m_sc++;
      if (mem_branch && m_fc != CMAX) m_fc++;
      if (mem_branch || lu) begin
        m_bubble();
      end else begin
        m_ctl = id_ctl(); m_aluc = id_aluc;
        m_a = id_a; m_b = id_b; m_imm = id_imm;
        m_rs = id_rs; m_rt = id_rt; m_rn = id_rn;
        m_fa = fa; m_fb = fb;
      end
    end
    #1;
  endtask

  task automatic id_nop();
    {id_wreg, id_m2reg, id_wmem, id_aluimm} = 4'b0;
    {id_shift, id_is_beq, id_is_bne, id_wz} = 4'b0;
    id_aluc = 0; id_a = 0; id_b = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rn = 0;
    id_use_rs = 0; id_use_rt = 0;
    mem_branch = 0; mem_rn = 0; mem_wreg = 0;
  endtask

  task automatic test_reset();
    id_nop();
    clrn = 1'b1;
    id_wreg = 1; id_rn = 5; id_a = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({exe_rn, exe_a, dut_ctl()} !== '0) begin
        n_bad++;
        $display("FAIL reset_out rn=%0d a=%h ctl=%b req 0",
                 exe_rn, exe_a, dut_ctl());
      end
      n_vec++;
      if ({stall_cnt, flush_cnt, stall} !== '0) begin
        n_bad++;
        $display("FAIL reset_cnt sc=%0d fc=%0d st=%b req 0",
                 stall_cnt, flush_cnt, stall);
      end
    end
    clrn = 1'b0;
    tick();
    n_vec++;
    if (exe_rn !== 5 || exe_a !== 32'h1234 ||
        exe_wreg !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release rn=%0d a=%h w=%b req 5 1234 1",
               exe_rn, exe_a, exe_wreg);
    end
  endtask

  task automatic test_load_use();
    logic [CW-1:0] sc0;
    id_nop();
    id_wreg = 1; id_m2reg = 1; id_rn = 8;
    tick();
    sc0 = m_sc;
    id_nop();
    id_wreg = 1; id_rs = 8; id_rt = 3; id_rn = 10;
    id_use_rs = 1; id_use_rt = 1; id_a = 32'hAAAA;
    #3;
    n_vec++;
    if (stall !== 1'b1) begin
      n_bad++;
      $display("FAIL lu_stall got %b req 1", stall);
    end
    tick();
    n_vec++;
    if (exe_wreg !== 0 || exe_rn !== 0 || exe_a !== 0) begin
      n_bad++;
      $display("FAIL lu_bubble w=%b rn=%0d a=%h req 0",
               exe_wreg, exe_rn, exe_a);
    end
    n_vec++;
    if (stall_cnt !== sc0 + 1'b1) begin
      n_bad++;
      $display("FAIL lu_cnt got %0d req %0d",
               stall_cnt, sc0 + 1'b1);
    end
    mem_rn = 8; mem_wreg = 1;
    #3;
    n_vec++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL lu_one_cycle got %b req 0", stall);
    end
    tick();
    n_vec++;
    if (exe_fwda !== 2'b10 || exe_rn !== 10) begin
      n_bad++;
      $display("FAIL lu_fwd_mem fa=%b rn=%0d req 10 10",
               exe_fwda, exe_rn);
    end
  endtask

  task automatic test_exe_priority();
    id_nop();
    id_wreg = 1; id_rn = 9;
    tick();
    id_nop();
    id_wreg = 1; id_rs = 4; id_rt = 9; id_rn = 11;
    id_use_rs = 1; id_use_rt = 1;
    mem_rn = 9; mem_wreg = 1;
    tick();
    n_vec++;
    if (exe_fwdb !== 2'b01 || exe_fwda !== 2'b00) begin
      n_bad++;
      $display("FAIL exe_prio fb=%b fa=%b req 01 00",
               exe_fwdb, exe_fwda);
    end
  endtask

  task automatic test_r0();
    id_nop();
    id_wreg = 1; id_rn = 0;
    tick();
    id_nop();
    id_rs = 0; id_use_rs = 1; id_wreg = 1; id_rn = 2;
    #3;
    n_vec++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL r0_stall got %b req 0", stall);
    end
    tick();
    n_vec++;
    if (exe_fwda !== 2'b00) begin
      n_bad++;
      $display("FAIL r0_fwd got %b req 00", exe_fwda);
    end
  endtask

  task automatic test_flush();
    logic [CW-1:0] sc0, fc0;
    id_nop();
    id_wreg = 1; id_m2reg = 1; id_rn = 8;
    tick();
    sc0 = m_sc;
    fc0 = m_fc;
    id_nop();
    id_wreg = 1; id_rs = 8; id_use_rs = 1; id_rn = 12;
    mem_branch = 1;
    #3;
    n_vec++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_stall got %b req 0", stall);
    end
    tick();
    n_vec++;
    if (exe_wreg !== 0 || exe_rn !== 0) begin
      n_bad++;
      $display("FAIL flush_bubble w=%b rn=%0d req 0",
               exe_wreg, exe_rn);
    end
    n_vec++;
    if (flush_cnt !== fc0 + 1'b1 || stall_cnt !== sc0) begin
      n_bad++;
      $display("FAIL flush_cnt fc=%0d sc=%0d req %0d %0d",
               flush_cnt, stall_cnt, fc0 + 1'b1, sc0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      {id_wreg, id_m2reg, id_wmem, id_aluimm} = 4'($urandom);
      {id_shift, id_is_beq, id_is_bne, id_wz} = 4'($urandom);
      id_aluc = 4'($urandom);
      id_a = $urandom; id_b = $urandom; id_imm = $urandom;
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      id_rn = 5'($urandom_range(0, 3));
      id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
      mem_branch = ($urandom_range(0, 9) == 0);
      mem_rn = 5'($urandom_range(0, 3));
      mem_wreg = 1'($urandom);
      #3;
      n_vec++;
      if (stall !== (exp_lu() && !mem_branch)) begin
        n_bad++;
        $display("FAIL rnd_stall i=%0d got %b req %b",
                 i, stall, exp_lu() && !mem_branch);
      end
      tick();
      n_vec++;
      if ({dut_ctl(), exe_aluc} !== {m_ctl, m_aluc}) begin
        n_bad++;
        $display("FAIL rnd_ctl i=%0d got %h req %h", i,
                 {dut_ctl(), exe_aluc}, {m_ctl, m_aluc});
      end
      n_vec++;
      if ({exe_a, exe_b, exe_imm} !== {m_a, m_b, m_imm}) begin
        n_bad++;
        $display("FAIL rnd_data i=%0d got %h req %h", i,
                 {exe_a, exe_b, exe_imm}, {m_a, m_b, m_imm});
      end
      n_vec++;
      if ({exe_rs, exe_rt, exe_rn, exe_fwda, exe_fwdb} !==
          {m_rs, m_rt, m_rn, m_fa, m_fb}) begin
        n_bad++;
        $display("FAIL rnd_regs i=%0d got %h req %h", i,
                 {exe_rs, exe_rt, exe_rn, exe_fwda, exe_fwdb},
                 {m_rs, m_rt, m_rn, m_fa, m_fb});
      end
      n_vec++;
      if ({stall_cnt, flush_cnt} !== {m_sc, m_fc}) begin
        n_bad++;
        $display("FAIL rnd_cnt i=%0d sc=%0d fc=%0d req %0d %0d",
                 i, stall_cnt, flush_cnt, m_sc, m_fc);
      end
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 20; k++) begin
      id_nop();
      id_wreg = 1; id_m2reg = 1; id_rn = 6;
      if (k % 3 == 0) mem_branch = 1;
      tick();
      id_nop();
      id_rt = 6; id_use_rt = 1; id_wreg = 1; id_rn = 7;
      if (k % 3 == 0) mem_branch = 1;
      tick();
    end
    n_vec++;
    if (stall_cnt !== CMAX || flush_cnt !== CMAX) begin
      n_bad++;
      $display("FAIL sat_cnt sc=%0d fc=%0d req %0d",
               stall_cnt, flush_cnt, CMAX);
    end
    id_nop();
    id_wreg = 1; id_m2reg = 1; id_rn = 6;
    tick();
    id_nop();
    id_rs = 6; id_use_rs = 1;
    #3;
    n_vec++;
    if (stall !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_stall got %b req 1", stall);
    end
    tick();
    n_vec++;
    if (stall_cnt !== CMAX) begin
      n_bad++;
      $display("FAIL sat_hold got %0d req %0d", stall_cnt, CMAX);
    end
  endtask

  task automatic test_reset_mid_stall();
    id_nop();
    id_wreg = 1; id_m2reg = 1; id_rn = 5;
    tick();
    id_nop();
    id_rs = 5; id_use_rs = 1;
    clrn = 1'b1;
    #3;
    n_vec++;
    if (stall !== 1'b0 || stall_cnt !== 0) begin
      n_bad++;
      $display("FAIL rst_mid st=%b sc=%0d req 0 0",
               stall, stall_cnt);
    end
    tick();
    clrn = 1'b0;
  endtask

  initial begin
    m_bubble();
    m_sc = 0;
    m_fc = 0;
    test_reset();
    test_load_use();
    test_exe_priority();
    test_r0();
    test_flush();
    test_random();
    test_saturation();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
